image_fetch_block: RTL and testbench

Parametrised successor to the CNN image loader: fetches a square feature map of `size`×`size` words from CNN memory, using the multi-word burst read, into a flat on-chip buffer. The CNN controller consumes the buffer. Beyond the fixed loader, it adds:

- a configurable buffer depth and burst width;
- optional zero-padding of the map border;
- a size error flag.

It sits between the CNN controller (enable/done handshake) and the CNN memory read port.

---
 rtl/img_fetch_pkg.sv | 20 ++
 rtl/image_fetch_block.sv | 165 ++++++++++++++++
 tb/tb_image_fetch_block.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/img_fetch_pkg.sv
// Shared definitions for the image fetch block: FSM state encoding,
// default geometry constants and the signed buffer word type.
package img_fetch_pkg;

    localparam int DEFAULT_BEAT     = 25;
    localparam int DEFAULT_MAX_SIZE = 32;
    localparam int DEFAULT_DATA_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_REQ   = 3'd2,
        ST_CAP   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } fetch_state_t;

    typedef logic signed [DEFAULT_DATA_W-1:0] word_t;

endpackage

// File: rtl/image_fetch_block.sv
// image_fetch_block: copies a size x size feature map from CNN memory into a
// flat on-chip buffer using BEAT-word burst reads, one beat per REQ/CAP pair.
// Optional border zero-padding is compiled in with IMG_FETCH_PAD_EN; without
// it the pad input is ignored and outSize equals size.
//
// state | meaning
// IDLE  | waiting for enable; latches size/pad/address on enable
// CLEAR | zeroes the whole buffer, resets row/column counters
// REQ   | drives the burst read strobe and address
// CAP   | stores the returned words and advances row/column
// DONE  | transfer complete, done held while enable stays high
// ERR   | illegal size, done and err held while enable stays high
module image_fetch_block
    import img_fetch_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = 16,
    parameter int MAX_SIZE = DEFAULT_MAX_SIZE,
    parameter int BEAT     = DEFAULT_BEAT
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enable,
    input  logic [15:0]                         size,
    input  logic [3:0]                          pad,
    input  logic [ADDR_W-1:0]                   address,
    output logic [ADDR_W-1:0]                   dmaAddr,
    output logic                                dmaEn,
    input  logic [BEAT*DATA_W-1:0]              dmaOut,
    output logic [MAX_SIZE*MAX_SIZE*DATA_W-1:0] out,
    output logic [15:0]                         outSize,
    output logic                                done,
    output logic                                err
);

    localparam int DEPTH = MAX_SIZE * MAX_SIZE;
    localparam int IDX_W = $clog2(DEPTH);

    fetch_state_t r_state;
    fetch_state_t w_next;

    logic [15:0]             r_size;
    logic [15:0]             r_out_size;
    logic [15:0]             r_row;
    logic [15:0]             r_col;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_done;
    logic                    r_err;
    logic signed [DATA_W-1:0] r_buf [DEPTH];

    logic [16:0]             w_out_size_in;
    logic                    w_size_bad;
    logic [15:0]             w_rem;
    logic [15:0]             w_n;
    logic [15:0]             w_col_next;
    logic                    w_row_end;
    logic                    w_last;
    logic [IDX_W-1:0]        w_base;

`ifdef IMG_FETCH_PAD_EN
    logic [3:0]              r_pad;

    assign w_out_size_in = 17'(size) + 17'({pad, 1'b0});
    // The source row r lands at buffer row r+pad, shifted right by pad.
    assign w_base = IDX_W'((32'(r_row) + 32'(r_pad)) * 32'(r_out_size)
                           + 32'(r_pad) + 32'(r_col));
`else
    logic                    w_unused_pad;

    assign w_unused_pad  = ^pad;
    assign w_out_size_in = 17'(size);
    assign w_base = IDX_W'(32'(r_row) * 32'(r_out_size) + 32'(r_col));
`endif

    // The padded side is checked in 17 bits so a huge size cannot wrap past the limit.
    assign w_size_bad = (size == 16'd0) || (w_out_size_in > 17'(MAX_SIZE));

    // A beat is clipped at the end of the current row.
    assign w_rem      = r_size - r_col;
    assign w_n        = (w_rem > 16'(BEAT)) ? 16'(BEAT) : w_rem;
    assign w_col_next = r_col + w_n;
    assign w_row_end  = (w_col_next == r_size);
    assign w_last     = w_row_end && ((r_row + 16'd1) == r_size);

    assign dmaEn   = (r_state == ST_REQ);
    assign dmaAddr = dmaEn ? (r_addr + ADDR_W'(32'(r_row) * 32'(r_size)) + ADDR_W'(r_col))
                           : '0;
    assign outSize = r_out_size;
    assign done    = r_done;
    assign err     = r_err;

    // Next-state selection; dropping enable anywhere returns to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (enable) w_next = w_size_bad ? ST_ERR : ST_CLEAR;
            ST_CLEAR: w_next = enable ? ST_REQ : ST_IDLE;
            ST_REQ:   w_next = enable ? ST_CAP : ST_IDLE;
            ST_CAP:   w_next = enable ? (w_last ? ST_DONE : ST_REQ) : ST_IDLE;
            ST_DONE:  w_next = enable ? ST_DONE : ST_IDLE;
            ST_ERR:   w_next = enable ? ST_ERR : ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // State, latched request parameters, row/column counters and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_size     <= '0;
            r_out_size <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_addr     <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef IMG_FETCH_PAD_EN
            r_pad      <= '0;
`endif
        end else begin
            r_state <= w_next;
            r_done  <= enable && ((r_state == ST_DONE) || (r_state == ST_ERR));
            r_err   <= enable && (r_state == ST_ERR);
            if ((r_state == ST_IDLE) && enable) begin
                r_size     <= size;
                r_out_size <= w_out_size_in[15:0];
                r_addr     <= address;
`ifdef IMG_FETCH_PAD_EN
                r_pad      <= pad;
`endif
            end
            if (r_state == ST_CLEAR) begin
                r_row <= '0;
                r_col <= '0;
            end else if ((r_state == ST_CAP) && enable) begin
                if (w_row_end) begin
                    r_col <= '0;
                    r_row <= r_row + 16'd1;
                end else begin
                    r_col <= w_col_next;
                end
            end
        end
    end

    // Buffer: cleared on reset and in CLEAR, filled beat by beat in CAP.
    always_ff @(posedge clk) begin
        if (reset || (r_state == ST_CLEAR)) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[IDX_W'(i)] <= '0;
            end
        end else if ((r_state == ST_CAP) && enable) begin
            for (int k = 0; k < BEAT; k++) begin
                if (16'(k) < w_n) begin
                    r_buf[w_base + IDX_W'(k)] <= $signed(dmaOut[k*DATA_W +: DATA_W]);
                end
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_out
        assign out[g*DATA_W +: DATA_W] = r_buf[g];
    end

endmodule

// File: tb/tb_image_fetch_block.sv
// Directed bench for image_fetch_block. Memory model: mem[a] = a - 99
// (16-bit wrap), so mem[100+i] = i+1.
module tb_image_fetch_block;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int MS = 32;
    localparam int BT = 25;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic [15:0]          size;
    logic [3:0]           pad;
    logic [AW-1:0]        address;
    logic [AW-1:0]        dmaAddr;
    logic                 dmaEn;
    logic [BT*DW-1:0]     dmaOut;
    logic [MS*MS*DW-1:0]  out;
    logic [15:0]          outSize;
    logic                 done;
    logic                 err;

    image_fetch_block #(.DATA_W(DW), .ADDR_W(AW), .MAX_SIZE(MS), .BEAT(BT)) dut (
        .clk(clk), .reset(reset), .enable(enable), .size(size), .pad(pad),
        .address(address), .dmaAddr(dmaAddr), .dmaEn(dmaEn), .dmaOut(dmaOut),
        .out(out), .outSize(outSize), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [AW-1:0]    addr_q[$];
    logic [BT*DW-1:0] mem_rd;

    // Memory read port with one cycle latency; also logs every read address.
    always @(posedge clk) begin
        if (dmaEn) begin
            for (int k = 0; k < BT; k++) mem_rd[k*DW +: DW] = dmaAddr + 16'(k) - 16'd99;
            dmaOut <= mem_rd;
            addr_q.push_back(dmaAddr);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] word(input int idx);
        return out[idx*DW +: DW];
    endfunction

    // Raise enable, return the index of the edge after which done is seen (-1 on timeout).
    task automatic run_fetch(input int sz, input int pd, input int ad, output int cyc);
        addr_q.delete();
        cyc = -1;
        @(negedge clk);
        size = 16'(sz); pad = 4'(pd); address = 16'(ad); enable = 1'b1;
        for (int e = 0; e < 300; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                cyc = e;
                break;
            end
        end
    endtask

    task automatic release_en(input string tag);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_low"}, 64'(done), 64'd0);
        chk({tag, "_err_low"}, 64'(err), 64'd0);
        chk({tag, "_dmaen_low"}, 64'(dmaEn), 64'd0);
    endtask

    // sz, pd, ad, cyc, osz, er, beats, a_first, a_last, chk_idx, chk_val, zero_idx
    typedef struct {
        int sz; int pd; int ad; int cyc; int osz; int er; int beats;
        int af; int al; int ci; int cv; int zi;
    } vec_t;

    vec_t vq[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        string nm;

        vq.push_back('{32, 0, 100, 130, 32, 0, 64, 100, 1117, 1023, 1024, -1});
        vq.push_back('{ 6, 0, 100,  14,  6, 0,  6, 100,  130,   35,   36, 36});
        vq.push_back('{30, 0, 100, 122, 30, 0, 60, 100,  995,  899,  900, 900});
        vq.push_back('{ 1, 0, 100,   4,  1, 0,  1, 100,  100,    0,    1, 1});
        vq.push_back('{25, 0, 100,  52, 25, 0, 25, 100,  700,  624,  625, 625});
        vq.push_back('{26, 0, 100, 106, 26, 0, 52, 100,  775,  675,  676, 676});
        vq.push_back('{ 2, 0, 16'hFFFF, 6, 2, 0, 2, 16'hFFFF, 1, 1, 16'hFF9D, 4});
        vq.push_back('{ 0, 0, 100,   1,  0, 1,  0,   0,    0,   -1,    0, -1});
        vq.push_back('{33, 0, 100,   1, 33, 1,  0,   0,    0,   -1,    0, -1});
`ifdef IMG_FETCH_PAD_EN
        vq.push_back('{ 6, 1, 100,  14,  8, 0,  6, 100,  130,    9,    1, 63});
        vq.push_back('{30, 1, 100, 122, 32, 0, 60, 100,  995,   33,    1, 0});
        vq.push_back('{31, 1, 100,   1, 33, 1,  0,   0,    0,   -1,    0, -1});
`else
        vq.push_back('{ 6, 3, 100,  14,  6, 0,  6, 100,  130,    0,    1, 36});
`endif

        reset = 1'b1; enable = 1'b0; size = '0; pad = '0; address = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dmaen", 64'(dmaEn), 64'd0);
        chk("rst_dmaaddr", 64'(dmaAddr), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_outsize", 64'(outSize), 64'd0);
        chk("rst_out_zero", 64'(|out), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            nm = $sformatf("vec%0d", i);
            run_fetch(vq[i].sz, vq[i].pd, vq[i].ad, cyc);
            chk({nm, "_done_cycle"}, 64'(cyc), 64'(vq[i].cyc));
            chk({nm, "_err"}, 64'(err), 64'(vq[i].er));
            chk({nm, "_outsize"}, 64'(outSize), 64'(vq[i].osz));
            if (vq[i].beats > 0) begin
                chk({nm, "_first_addr"}, 64'(addr_q[0]), 64'(vq[i].af));
                chk({nm, "_last_addr"}, 64'(addr_q[addr_q.size()-1]), 64'(vq[i].al));
            end
            if (vq[i].ci >= 0) chk({nm, "_word"}, 64'(word(vq[i].ci)), 64'(vq[i].cv));
            if (vq[i].zi >= 0) chk({nm, "_tail_zero"}, 64'(word(vq[i].zi)), 64'd0);
            release_en(nm);
            chk({nm, "_beats"}, 64'(addr_q.size()), 64'(vq[i].beats));
        end

        // Full contents and address trail of the single-beat-row case.
        run_fetch(6, 0, 100, cyc);
        chk("s6_cycle", 64'(cyc), 64'd14);
        for (int i = 0; i < 36; i++) chk($sformatf("s6_out%0d", i), 64'(word(i)), 64'(i + 1));
        for (int i = 0; i < 6; i++) chk($sformatf("s6_addr%0d", i), 64'(addr_q[i]), 64'(100 + 6*i));
        release_en("s6");

        // Multi-beat rows: row end of first row and the 25/5 split of each row.
        run_fetch(30, 0, 100, cyc);
        chk("s30_out29", 64'(word(29)), 64'd30);
        chk("s30_addr1", 64'(addr_q[1]), 64'd125);
        chk("s30_addr2", 64'(addr_q[2]), 64'd130);
        chk("s30_addr3", 64'(addr_q[3]), 64'd155);
        release_en("s30");

`ifdef IMG_FETCH_PAD_EN
        // Padded layout around the first two rows.
        run_fetch(6, 1, 100, cyc);
        for (int i = 0; i < 9; i++) chk($sformatf("pad_top%0d", i), 64'(word(i)), 64'd0);
        chk("pad_out9", 64'(word(9)), 64'd1);
        chk("pad_out14", 64'(word(14)), 64'd6);
        chk("pad_out15", 64'(word(15)), 64'd0);
        chk("pad_out16", 64'(word(16)), 64'd0);
        chk("pad_out17", 64'(word(17)), 64'd7);
        chk("pad_out63", 64'(word(63)), 64'd0);
        release_en("pad");
`endif

        // Abort: enable drops while the third beat is being requested.
        addr_q.delete();
        @(negedge clk);
        size = 16'd6; pad = 4'd0; address = 16'd100; enable = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_dmaen", 64'(dmaEn), 64'd0);
        chk("abort_dmaaddr", 64'(dmaAddr), 64'd0);
        chk("abort_keep_row1", 64'(word(6)), 64'd7);
        chk("abort_unwritten", 64'(word(12)), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("abort_idle_dmaen", 64'(dmaEn), 64'd0);
        run_fetch(6, 0, 100, cyc);
        chk("reen_first_addr", 64'(addr_q[0]), 64'd100);
        chk("reen_cycle", 64'(cyc), 64'd14);
        chk("reen_out35", 64'(word(35)), 64'd36);
        release_en("reen");

        // Reset in the middle of a transfer.
        @(negedge clk);
        size = 16'd6; pad = 4'd0; address = 16'd100; enable = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_dmaen", 64'(dmaEn), 64'd0);
        chk("mrst_dmaaddr", 64'(dmaAddr), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        chk("mrst_err", 64'(err), 64'd0);
        chk("mrst_outsize", 64'(outSize), 64'd0);
        chk("mrst_out_zero", 64'(|out), 64'd0);
        reset = 1'b0;
        enable = 1'b0;
        addr_q.delete();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("mrst_no_restart", 64'(addr_q.size()), 64'd0);
        run_fetch(6, 0, 100, cyc);
        chk("mrst_rerun_cycle", 64'(cyc), 64'd14);
        chk("mrst_rerun_addr", 64'(addr_q[0]), 64'd100);
        chk("mrst_rerun_out0", 64'(word(0)), 64'd1);
        release_en("mrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
